// File: rtl/subbytes_quad_predictor_sweep_if.sv
// ---------------------------------------------------------------------------
// subbytes_quad_predictor_sweep_if
// Handshake bundle between a plaintext source / prediction sink and the
// SubBytes key-sweep leakage predictor.
//   in_valid / in_ready / in_data   : plaintext word, LANES bytes
//   out_valid / out_ready           : prediction handshake
//   out_key, out_pred, out_last     : key hypothesis, LANES 4-bit predictions,
//                                     marker for the final hypothesis
// master : the testbench / upstream side, slave : the predictor.
// ---------------------------------------------------------------------------
interface subbytes_quad_predictor_sweep_if #(
    parameter int LANES = 1
);
    logic               in_valid;
    logic               in_ready;
    logic [8*LANES-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_key;
    logic [4*LANES-1:0] out_pred;
    logic               out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_key, out_pred, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_key, out_pred, out_last
    );
endinterface

// File: rtl/subbytes_quad_predictor_sweep.sv
// ---------------------------------------------------------------------------
// subbytes_quad_predictor_sweep
// Streaming AES first-round SubBytes leakage predictor. A plaintext word of
// LANES bytes is latched, then key hypotheses KEY_FIRST..KEY_LAST are swept,
// one per cycle, producing f(SubBytes(pt ^ k)) for every lane.
//   f, MODE 0 : GF(2^4) product (x^4+x+1) of SubBytes high and low nibbles
//   f, MODE 1 : Hamming weight of the SubBytes output
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of subbytes_quad_predictor_sweep_if
//   busy     : high while a sweep or its pipeline drain is in progress
// Optional build macro SBQP_HD_EN: each lane outputs pred(k) ^ pred(k-1),
// with the previous value cleared at sweep start.
// ---------------------------------------------------------------------------
module subbytes_quad_predictor_sweep #(
    parameter int         LANES     = 1,
    parameter int         MODE      = 0,
    parameter logic [7:0] KEY_FIRST = 8'h00,
    parameter logic [7:0] KEY_LAST  = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    subbytes_quad_predictor_sweep_if.slave bus,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} stateT;

    // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gfMul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // GF(2^4) multiply modulo x^4+x+1, polynomial basis.
    function automatic logic [3:0] gfMul4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    // SubBytes: multiplicative inverse as x^254 (0 maps to 0), then affine map.
    function automatic logic [7:0] sBox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] res;
        logic [7:0] cst;
        cst = 8'h63;
        sq  = gfMul8(x, x);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gfMul8(sq, sq);
            inv = gfMul8(inv, sq);
        end
        for (int i = 0; i < 8; i++) begin
            res[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                   ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ cst[i];
        end
        return res;
    endfunction

    function automatic logic [3:0] predict(input logic [7:0] s);
        logic [3:0] res;
        if (MODE == 1) begin
            res = 4'd0;
            for (int i = 0; i < 8; i++) res = res + {3'b000, s[i]};
        end else begin
            res = gfMul4(s[7:4], s[3:0]);
        end
        return res;
    endfunction

    stateT              state;
    stateT              nextState;
    logic [8*LANES-1:0] ptReg;
    logic [7:0]         keyCnt;
    logic               advance;
    logic               accept;
    logic               issue;
    logic               retire;
    logic [8*LANES-1:0] issueX;
    logic [8*LANES-1:0] sbNext;
    logic [4*LANES-1:0] fNext;
    logic [4*LANES-1:0] predNext;

    logic               vld_p1;
    logic               last_p1;
    logic [7:0]         key_p1;
    logic [8*LANES-1:0] sBox_p1;
    logic               vld_p2;
    logic               last_p2;
    logic [7:0]         key_p2;
    logic [4*LANES-1:0] pred_p2;

    assign advance = !vld_p2 || bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;
    assign issue   = (state == SWEEP) && advance;
    assign retire  = vld_p2 && last_p2 && bus.out_ready;
    assign issueX  = ptReg ^ {LANES{keyCnt}};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = SWEEP;
            SWEEP:   if (issue && (keyCnt == KEY_LAST)) nextState = DRAIN;
            DRAIN:   if (retire) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Stage 0 -> 1: SubBytes of the key-mixed plaintext bytes
    always_comb begin
        sbNext = '0;
        for (int i = 0; i < LANES; i++) sbNext[8*i +: 8] = sBox(issueX[8*i +: 8]);
    end

    // Stage 1 -> 2: leakage function per lane
    always_comb begin
        fNext = '0;
        for (int i = 0; i < LANES; i++) fNext[4*i +: 4] = predict(sBox_p1[8*i +: 8]);
    end

`ifdef SBQP_HD_EN
    logic [4*LANES-1:0] prevPred;

    // Holds the raw prediction of the previous key; zero at sweep start so the
    // first output of a sweep is the raw pred(KEY_FIRST).
    always_ff @(posedge clk) begin
        if (rst || accept)         prevPred <= '0;
        else if (advance && vld_p1) prevPred <= fNext;
    end

    assign predNext = fNext ^ prevPred;
`else
    assign predNext = fNext;
`endif

    // Key counter stops at KEY_LAST rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            keyCnt  <= 8'h00;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            key_p2  <= 8'h00;
            pred_p2 <= '0;
        end else begin
            if (accept)                                keyCnt <= KEY_FIRST;
            else if (issue && (keyCnt != KEY_LAST))    keyCnt <= keyCnt + 8'd1;
            if (advance) begin
                vld_p1 <= issue;
                if (issue) last_p1 <= (keyCnt == KEY_LAST);
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    last_p2 <= last_p1;
                    key_p2  <= key_p1;
                    pred_p2 <= predNext;
                end
            end
        end
    end

    // Datapath registers qualified by valid bits need no reset.
    always_ff @(posedge clk) begin
        if (accept) ptReg <= bus.in_data;
        if (advance && issue) begin
            sBox_p1 <= sbNext;
            key_p1  <= keyCnt;
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = vld_p2;
    assign bus.out_key   = key_p2;
    assign bus.out_pred  = pred_p2;
    assign bus.out_last  = last_p2;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_subbytes_quad_predictor_sweep.sv
// ---------------------------------------------------------------------------
// tb_subbytes_quad_predictor_sweep
// Bench for subbytes_quad_predictor_sweep. Four instances with different
// LANES / MODE / key ranges share one clock and reset; a selector routes the
// common stimulus and monitor to one instance at a time. The reference uses a
// SubBytes table built by inverse search plus the rotation form of the affine
// map, and plain field arithmetic for the leakage functions.
// ---------------------------------------------------------------------------
module tb_subbytes_quad_predictor_sweep;

`ifdef SBQP_HD_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [15:0] expPred;
    } vecT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFails  = 0;
    int          sel;
    logic        tbInValid;
    logic        tbOutReady;
    logic [31:0] tbInData;
    logic [7:0]  sboxTab [256];

    int cfgLanes, cfgMode, cfgFirst, cfgLast;

    logic busyA, busyB, busyC, busyD;
    logic        curInReady, curOutValid, curOutLast, curBusy;
    logic [7:0]  curOutKey;
    logic [15:0] curOutPred;

    subbytes_quad_predictor_sweep_if #(.LANES(1)) ifA();
    subbytes_quad_predictor_sweep_if #(.LANES(3)) ifB();
    subbytes_quad_predictor_sweep_if #(.LANES(4)) ifC();
    subbytes_quad_predictor_sweep_if #(.LANES(2)) ifD();

    subbytes_quad_predictor_sweep #(.LANES(1), .MODE(1), .KEY_FIRST(8'h00), .KEY_LAST(8'hFF))
        dutA (.clk(clk), .rst(rst), .bus(ifA), .busy(busyA));
    subbytes_quad_predictor_sweep #(.LANES(3), .MODE(0), .KEY_FIRST(8'h00), .KEY_LAST(8'h00))
        dutB (.clk(clk), .rst(rst), .bus(ifB), .busy(busyB));
    subbytes_quad_predictor_sweep #(.LANES(4), .MODE(0), .KEY_FIRST(8'hF0), .KEY_LAST(8'hFF))
        dutC (.clk(clk), .rst(rst), .bus(ifC), .busy(busyC));
    subbytes_quad_predictor_sweep #(.LANES(2), .MODE(1), .KEY_FIRST(8'h00), .KEY_LAST(8'h01))
        dutD (.clk(clk), .rst(rst), .bus(ifD), .busy(busyD));

    assign ifA.in_valid  = (sel == 0) && tbInValid;
    assign ifB.in_valid  = (sel == 1) && tbInValid;
    assign ifC.in_valid  = (sel == 2) && tbInValid;
    assign ifD.in_valid  = (sel == 3) && tbInValid;
    assign ifA.in_data   = tbInData[7:0];
    assign ifB.in_data   = tbInData[23:0];
    assign ifC.in_data   = tbInData;
    assign ifD.in_data   = tbInData[15:0];
    assign ifA.out_ready = (sel == 0) ? tbOutReady : 1'b1;
    assign ifB.out_ready = (sel == 1) ? tbOutReady : 1'b1;
    assign ifC.out_ready = (sel == 2) ? tbOutReady : 1'b1;
    assign ifD.out_ready = (sel == 3) ? tbOutReady : 1'b1;

    always_comb begin
        curInReady  = ifA.in_ready;
        curOutValid = ifA.out_valid;
        curOutLast  = ifA.out_last;
        curOutKey   = ifA.out_key;
        curOutPred  = {12'h000, ifA.out_pred};
        curBusy     = busyA;
        case (sel)
            1: begin
                curInReady = ifB.in_ready;  curOutValid = ifB.out_valid;
                curOutLast = ifB.out_last;  curOutKey   = ifB.out_key;
                curOutPred = {4'h0, ifB.out_pred}; curBusy = busyB;
            end
            2: begin
                curInReady = ifC.in_ready;  curOutValid = ifC.out_valid;
                curOutLast = ifC.out_last;  curOutKey   = ifC.out_key;
                curOutPred = ifC.out_pred;  curBusy     = busyC;
            end
            3: begin
                curInReady = ifD.in_ready;  curOutValid = ifD.out_valid;
                curOutLast = ifD.out_last;  curOutKey   = ifD.out_key;
                curOutPred = {8'h00, ifD.out_pred}; curBusy = busyD;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] refMul8(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [3:0] refMul4(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [3:0] model(input int mode, input logic [7:0] p, input logic [7:0] k);
        logic [7:0] s;
        s = sboxTab[p ^ k];
        if (mode == 1) return 4'($countones(s));
        return refMul4(s[7:4], s[3:0]);
    endfunction

    task automatic setSel(input int s);
        sel = s;
        case (s)
            0: begin cfgLanes = 1; cfgMode = 1; cfgFirst = 8'h00; cfgLast = 8'hFF; end
            1: begin cfgLanes = 3; cfgMode = 0; cfgFirst = 8'h00; cfgLast = 8'h00; end
            2: begin cfgLanes = 4; cfgMode = 0; cfgFirst = 8'hF0; cfgLast = 8'hFF; end
            default: begin cfgLanes = 2; cfgMode = 1; cfgFirst = 8'h00; cfgLast = 8'h01; end
        endcase
    endtask

    // One word through the selected instance: accept, then monitor every
    // handshake against the model. abortKey >= 0 pulses rst when that key
    // is presented. b2b expects acceptance on the very first cycle.
    task automatic runSweep(input logic [31:0] pt, input bit stall, input bit keepValid,
                            input bit b2b, input int abortKey,
                            output logic [15:0] firstPred, output logic [15:0] lastPred);
        int          firstLat, hs, lastIdx, nExp, expKey, inReadyBad, busyBad;
        bit          acc, pend, done, rdy;
        logic [3:0]  prevRaw [4];
        logic [3:0]  raw;
        logic [15:0] exp;
        logic [7:0]  pKey;
        logic [15:0] pPred;
        logic        pLast;

        firstPred = '0; lastPred = '0;
        acc = 0; pend = 0; done = 0;
        firstLat = -1; hs = 0; lastIdx = 0; inReadyBad = 0; busyBad = 0;
        pKey = '0; pPred = '0; pLast = 1'b0;
        nExp = cfgLast - cfgFirst + 1;
        expKey = cfgFirst;
        for (int l = 0; l < 4; l++) prevRaw[l] = 4'h0;

        for (int w = 0; w < 20 && !acc; w++) begin
            @(negedge clk);
            tbInValid = 1'b1;
            tbInData  = pt;
            if (w == 0 && b2b) begin
                chk("b2b_gap_in_ready", 32'(curInReady), 32'd1);
                chk("b2b_gap_busy", 32'(curBusy), 32'd0);
            end
            chk("idle_out_valid", 32'(curOutValid), 32'd0);
            if (curInReady) acc = 1;
        end
        chk("accept_seen", 32'(acc), 32'd1);
        if (!acc) begin
            tbInValid = 1'b0;
            return;
        end

        for (int idx = 1; idx < 4000 && !done; idx++) begin
            @(negedge clk);
            tbInValid  = keepValid;
            tbInData   = $urandom;
            rdy        = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            tbOutReady = rdy;
            if (pend)
                chk("stall_hold", {6'h0, curOutValid, curOutLast, curOutKey, curOutPred},
                                  {6'h0, 1'b1, pLast, pKey, pPred});
            pend = 0;
            if (curInReady) inReadyBad++;
            if (!curBusy)   busyBad++;
            if (abortKey >= 0 && curOutValid && (32'(curOutKey) == abortKey)) begin
                rst = 1'b1;
                #1;
                chk("rst_in_ready_low", 32'(curInReady), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                tbInValid = 1'b0;
                #1;
                chk("abort_out_valid", 32'(curOutValid), 32'd0);
                chk("abort_busy", 32'(curBusy), 32'd0);
                chk("abort_in_ready", 32'(curInReady), 32'd1);
                return;
            end
            if (curOutValid) begin
                if (firstLat < 0) firstLat = idx;
                if (rdy) begin
                    exp = '0;
                    for (int l = 0; l < cfgLanes; l++) begin
                        raw = model(cfgMode, pt[8*l +: 8], expKey[7:0]);
                        exp[4*l +: 4] = HD ? (raw ^ prevRaw[l]) : raw;
                        prevRaw[l] = raw;
                    end
                    chk("out_key", 32'(curOutKey), 32'(expKey[7:0]));
                    chk("out_pred", 32'(curOutPred), 32'(exp));
                    chk("out_last", 32'(curOutLast), 32'(expKey == cfgLast));
                    if (!HD && sel == 0 && pt == 32'h0) begin
                        if (expKey == 8'h00) chk("tp_key00_pred", 32'(curOutPred), 32'd4);
                        if (expKey == 8'h01) chk("tp_key01_pred", 32'(curOutPred), 32'd5);
                        if (expKey == 8'hFF) chk("tp_keyFF_pred", 32'(curOutPred), 32'd3);
                    end
                    if (hs == 0) firstPred = curOutPred;
                    lastPred = curOutPred;
                    hs++;
                    expKey++;
                    if (curOutLast || hs > nExp) begin
                        done = 1;
                        lastIdx = idx;
                        chk("retire_in_ready", 32'(curInReady), 32'd0);
                    end
                end else begin
                    pend  = 1;
                    pKey  = curOutKey;
                    pPred = curOutPred;
                    pLast = curOutLast;
                end
            end
        end
        chk("sweep_done", 32'(done), 32'd1);
        chk("handshake_count", 32'(hs), 32'(nExp));
        chk("first_latency", 32'(firstLat), 32'd3);
        if (!stall) chk("back_to_back_outputs", 32'(lastIdx - firstLat), 32'(nExp - 1));
        chk("in_ready_low_in_sweep", 32'(inReadyBad), 32'd0);
        chk("busy_high_in_sweep", 32'(busyBad), 32'd0);
    endtask

    initial begin
        vecT         tbl [4];
        logic [15:0] fp, lp;
        logic [7:0]  inv, s;

        tbl[0] = '{32'h0039_5234, 16'h0208};
        tbl[1] = '{32'h0000_01FF, 16'h0A26};
        tbl[2] = '{32'h0010_0203, 16'h0164};
        tbl[3] = '{32'h0009_1000, 16'h001A};

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (refMul8(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sboxTab[x] = s;
        end

        rst = 1'b1;
        tbInValid = 1'b0;
        tbOutReady = 1'b1;
        tbInData = '0;
        setSel(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            setSel(i);
            #1;
            chk("reset_in_ready", 32'(curInReady), 32'd0);
            chk("reset_outputs", {7'h0, curOutValid, curOutLast, curBusy, curOutKey, curOutPred},
                                 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            setSel(i);
            #1;
            chk("post_reset_in_ready", 32'(curInReady), 32'd1);
        end

        // Full MODE 1 sweep, no backpressure.
        setSel(0);
        runSweep(32'h00, 1'b0, 1'b0, 1'b0, -1, fp, lp);

        // Table of three-lane single-key vectors.
        setSel(1);
        for (int i = 0; i < 4; i++) begin
            runSweep(tbl[i].data, 1'b0, 1'b0, 1'b0, -1, fp, lp);
            chk($sformatf("table_vec%0d", i), 32'(fp), 32'(tbl[i].expPred));
        end

        // Backpressure, fixed and random plaintext.
        setSel(0);
        runSweep(32'h00, 1'b1, 1'b0, 1'b0, -1, fp, lp);
        runSweep(32'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, -1, fp, lp);

        // Reset mid-sweep, then a clean sweep.
        runSweep(32'h00, 1'b0, 1'b0, 1'b0, 8'h40, fp, lp);
        runSweep(32'h5A, 1'b0, 1'b0, 1'b0, -1, fp, lp);

        // Back-to-back words with in_valid held high.
        runSweep(32'h11, 1'b0, 1'b1, 1'b0, -1, fp, lp);
        runSweep(32'h22, 1'b0, 1'b0, 1'b1, -1, fp, lp);
        tbInValid = 1'b0;

        // Two-key sweep: 4 then 5 raw, 4 then 1 in distance form.
        setSel(3);
        runSweep(32'h0000, 1'b0, 1'b0, 1'b0, -1, fp, lp);
        chk("two_key_first", 32'(fp), 32'h0044);
        chk("two_key_second", 32'(lp), HD ? 32'h0011 : 32'h0055);

        // Four-lane MODE 0 ending at key 0xFF, random words and stalls.
        setSel(2);
        for (int i = 0; i < 3; i++)
            runSweep($urandom, 1'b1, 1'b0, 1'b0, -1, fp, lp);

        @(negedge clk);
        chk("final_idle_busy", 32'(curBusy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/subbytes_quad_predictor_sweep.md
Name: subbytes_quad_predictor_sweep

Overview:
Streaming side-channel leakage predictor for AES first-round SubBytes, successor to the single-byte combinational quadratic predictor.
- Accepts a plaintext word of LANES bytes and sweeps a key hypothesis k over KEY_FIRST..KEY_LAST.
- For each k, emits one prediction per lane: f(SubBytes(pt_byte ^ k)).
- Two-stage stall-able pipeline with valid/ready on both sides; feeds the correlation accumulator.

Parameters:
LANES, 1, number of plaintext bytes processed in parallel (1..16)
MODE, 0, 0 = quadratic (GF(2^4) product of SubBytes high and low nibbles via FFMul_K4_Q2); 1 = Hamming weight of SubBytes output
KEY_FIRST, 0, first key hypothesis (8-bit)
KEY_LAST, 255, last key hypothesis (8-bit, KEY_LAST >= KEY_FIRST)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  plaintext word valid
in_ready  out  1  block can accept a word
in_data  in  8*LANES  plaintext bytes; lane i = in_data[8i+7:8i]
out_valid  out  1  prediction valid
out_ready  in  1  downstream accepts prediction
out_key  out  8  key hypothesis of this prediction
out_pred  out  4*LANES  predictions; lane i = out_pred[4i+3:4i]
out_last  out  1  high with prediction for KEY_LAST
busy  out  1  sweep or pipeline drain in progress

Behaviour:
- Reset values: in_ready=0 during rst and 1 the cycle after; out_valid=0, out_key=0, out_pred=0, out_last=0, busy=0. Pipeline valid bits and key counter are cleared. Reset mid-sweep abandons the sweep with no further outputs.
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into pt_reg, set k=KEY_FIRST, go to SWEEP.
  - SWEEP: each cycle the pipeline advances, stage 0 issues (pt_reg ^ {LANES{k}}, k) and k increments. Issuing k=KEY_LAST goes to DRAIN.
  - DRAIN: no issue. Go to IDLE when the final output handshake (out_last&&out_valid&&out_ready) completes. in_ready=0 in SWEEP and DRAIN.
- Pipeline:
  - Stage 1 registers SubBytes(x) per lane plus key and last flag.
  - Stage 2 registers f() per lane plus key and last flag; it drives the out_* ports.
  - Latency: in_data accepted at cycle t gives the first prediction with out_valid at t+3; sustained throughput is 1 prediction/cycle with no stall.
- Stall rule: advance = !out_valid || out_ready. When advance=0, all stages, k and the FSM hold. out_* must not change while out_valid && !out_ready.
- f() widths:
  - MODE 0: 4-bit GF(2^4) product, field element 1 = 4'b0001.
  - MODE 1: popcount of 8 bits, range 0..8, fits 4 bits.
- k is an 8-bit counter with no wrap. KEY_FIRST==KEY_LAST gives one prediction per word, with out_last asserted on it.
- busy = (state != IDLE).
- A new word is not accepted in the same cycle the last output retires. in_ready rises the cycle after return to IDLE, so there is a 1-cycle gap between sweeps.

Optional Feature:
SBQP_HD_EN
- Defined: each lane outputs pred(k) XOR pred(k-1), a Hamming-distance style prediction. This adds a per-lane 4-bit previous register, loaded on stage-2 advance and cleared to 0 at sweep start, so the first output of a sweep equals pred(KEY_FIRST).
- Undefined: out_pred is the raw pred(k). No extra registers are built.

Test Plan:
1. MODE=1, LANES=1, full range, in_data=0x00, out_ready=1 -> 256 outputs on consecutive cycles, the first 3 cycles after accept. Key 0x00: pred 4 (S=0x63). Key 0x01: pred 5 (0x7C). Key 0xFF: pred 3 (0x16), with out_last=1 on it only.
2. MODE=0, KEY_FIRST=KEY_LAST=0, LANES=3, in_data={0x39,0x52,0x34} (lane2..lane0) -> single output, out_pred lane0=8 (S=0x18), lane1=0 (S=0x00), lane2=2 (S=0x12), out_last=1.
3. Backpressure: case 1 with out_ready toggled pseudo-randomly -> out_* stable while stalled, no key skipped or duplicated, exactly 256 handshakes in order 0x00..0xFF.
4. Reset mid-sweep: case 1, assert rst at key 0x40 for 1 cycle -> out_valid=0 and busy=0 next cycle. A new word then sweeps cleanly from KEY_FIRST.
5. Back-to-back words, in_valid held high, 2 words -> second accepted only after first out_last handshake. in_ready low throughout the first sweep, 1-cycle gap between sweeps.
6. SBQP_HD_EN, MODE=1, in_data=0x00, KEY_FIRST=0, KEY_LAST=1 -> outputs 4 then 4^5=1.
